instr_decode_stage: RTL

Pipeline decode stage that sits directly upstream of the ALU. It accepts 9-bit instructions from fetch over a valid/ready handshake and splits each one into the 3-bit opcode, register fields and an immediate. It buffers up to two decoded instructions, using an output register plus a skid register, so fetch-side ready is fully registered. Results go to the ALU / register-file stage in program order.

---
 rtl/instr_decode_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Brief    : 9-bit instruction decode with a two-entry output/skid buffer and
//            fully registered in_ready. Optional macro: DECODE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
    parameter int PC_W = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8:0]      in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_op,
    output logic [2:0]      out_rd,
    output logic [2:0]      out_rs,
    output logic [7:0]      out_imm,
    output logic            out_use_imm,
    output logic [PC_W-1:0] out_pc,
    output logic [15:0]     perf_count
);

    typedef struct packed {
        logic [2:0]      op;
        logic [2:0]      rd;
        logic [2:0]      rs;
        logic [7:0]      imm;
        logic            use_imm;
        logic [PC_W-1:0] pc;
    } entry_t;

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    localparam logic [2:0] c_OP_SHF  = 3'd6;
    localparam logic [2:0] c_OP_MOVI = 3'd7;

    logic [1:0] state_q, state_d;
    logic       in_ready_q;
    entry_t     out_q, skid_q;
    entry_t     w_dec;
    logic       w_accept, w_consume;
    logic       w_load_out, w_load_skid, w_move_skid;

    assign w_accept  = in_valid && in_ready_q;
    assign w_consume = out_valid && out_ready;

    always_comb begin
        w_dec         = '0;
        w_dec.op      = in_instr[8:6];
        w_dec.rd      = in_instr[5:3];
        w_dec.rs      = in_instr[2:0];
        w_dec.use_imm = (in_instr[8:6] == c_OP_SHF) || (in_instr[8:6] == c_OP_MOVI);
        w_dec.imm     = w_dec.use_imm ? {5'b0, in_instr[2:0]} : 8'h00;
        w_dec.pc      = in_pc;
    end

    // State register; in_ready is computed from the next state so it is a flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= c_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != c_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_EMPTY: if (w_accept) state_d = c_ONE;
            c_ONE: begin
                if (w_consume && !w_accept)      state_d = c_EMPTY;
                else if (!w_consume && w_accept) state_d = c_TWO;
            end
            c_TWO:   if (w_consume) state_d = c_ONE;
            default: state_d = c_EMPTY;
        endcase
        if (flush) state_d = c_EMPTY;
    end

    always_comb begin
        out_valid   = (state_q != c_EMPTY);
        in_ready    = in_ready_q;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        if (!flush) begin
            w_load_out  = w_accept && ((state_q == c_EMPTY) || ((state_q == c_ONE) && w_consume));
            w_load_skid = w_accept && (state_q == c_ONE) && !w_consume;
            w_move_skid = (state_q == c_TWO) && w_consume;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (w_load_out)       out_q <= w_dec;
            else if (w_move_skid) out_q <= skid_q;
            if (w_load_skid)      skid_q <= w_dec;
        end
    end

    assign out_op      = out_q.op;
    assign out_rd      = out_q.rd;
    assign out_rs      = out_q.rs;
    assign out_imm     = out_q.imm;
    assign out_use_imm = out_q.use_imm;
    assign out_pc      = out_q.pc;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_q;

    // Counts consumes even in a flush cycle; only Reset clears it.
    always_ff @(posedge Clk) begin
        if (Reset)          perf_q <= 16'h0000;
        else if (w_consume) perf_q <= perf_q + 16'd1;
    end

    assign perf_count = perf_q;
`else
    assign perf_count = 16'h0000;
`endif

endmodule
`default_nettype wire
